// File: rtl/uart_rx_basic_pkg.sv
// Shared UART definitions: FSM state encodings, frame constants and bit-period math.
// Used by both the receiver and the transmitter so their encodings never drift apart.
package uart_defs;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    START_BIT = 3'b001,
    DATA_BITS = 3'b010,
    STOP_BIT  = 3'b011
  } uart_state_t;

  localparam int DATA_BITS_N = 8;
  localparam int STOP_BITS_N = 1;

  // Integer divide on purpose: the bit period is rounded down to whole clocks.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_basic_sync.sv
// Two-flop synchroniser for a single asynchronous input; reset value is a parameter.
// Latency: 2 clk cycles. No backpressure (pure pipeline).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_basic.sv
// 8N1 UART receiver: 2-flop synchronised input, mid-bit sampling, one-cycle valid/frame-error strobes.
// Latency ~2 + HALF + 9*CLKS_PER_BIT clocks from the start edge; no backpressure, data_out is overwritten.
module uart_rx_basic
  import uart_defs::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS_N - 1);

  logic             rx_s;
  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START_BIT;
      end

      // Re-check the line at mid-start-bit so short low glitches are dropped.
      START_BIT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA_BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA_BITS: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP_BIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Leaving at mid-stop-bit leaves half a bit of slack to catch a back-to-back start.
      STOP_BIT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_basic.sv
// Directed bench for uart_rx_basic at 10 clocks per bit; strobes are logged by cycle number.
module tb_uart_rx_basic;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         valid_t[$];
  logic [7:0] valid_d[$];
  int         ferr_t[$];
  int         both_hi   = 0;
  int         busy_rise = -1;
  int         busy_fall = -1;
  logic       prev_busy = 1'b0;

  uart_rx_basic #(
    .CLK_FREQ  (1000000),
    .BAUD_RATE (100000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      valid_t.push_back(cyc);
      valid_d.push_back(data_out);
    end
    if (frame_error) ferr_t.push_back(cyc);
    if (data_valid && frame_error) both_hi++;
    if (busy && !prev_busy) busy_rise = cyc;
    if (!busy && prev_busy) busy_fall = cyc;
    prev_busy = busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int vt_at(input int i);
    return (i < valid_t.size()) ? valid_t[i] : -1;
  endfunction

  function automatic logic [7:0] vd_at(input int i);
    return (i < valid_d.size()) ? valid_d[i] : 8'hxx;
  endfunction

  function automatic int ft_at(input int i);
    return (i < ferr_t.size()) ? ferr_t[i] : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full 8N1 frame (100 clocks), LSB first; stop_val lets a bad stop bit be sent.
  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    rx = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) step();
    end
    rx = stop_val;
    repeat (CPB) step();
  endtask

  initial begin
    int t0, nv, nf;
    logic [7:0] b;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) step();
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_ferr", frame_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (20) step();
    check("idle_busy", busy, 1'b0);

    // 1: clean 0xA5
    nv = valid_t.size(); nf = ferr_t.size(); t0 = cyc;
    send_byte(8'hA5, 1'b1);
    repeat (20) step();
    check("t1_nvalid", valid_t.size() - nv, 1);
    check("t1_data", vd_at(nv), 8'hA5);
    check("t1_vtime", vt_at(nv), t0 + 98);
    check("t1_nferr", ferr_t.size() - nf, 0);
    check("t1_busy_rise", busy_rise, t0 + 3);
    check("t1_busy_fall", busy_fall, t0 + 98);
    check("t1_data_out", data_out, 8'hA5);

    // 2: back-to-back 0x00, 0xFF
    nv = valid_t.size(); t0 = cyc;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (20) step();
    check("t2_nvalid", valid_t.size() - nv, 2);
    check("t2_data0", vd_at(nv), 8'h00);
    check("t2_data1", vd_at(nv + 1), 8'hFF);
    check("t2_vtime0", vt_at(nv), t0 + 98);
    check("t2_spacing", vt_at(nv + 1) - vt_at(nv), 100);

    // 3: 0x3C with stop bit low
    nv = valid_t.size(); nf = ferr_t.size(); t0 = cyc;
    send_byte(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (30) step();
    check("t3_nferr", ferr_t.size() - nf, 1);
    check("t3_ftime", ft_at(nf), t0 + 98);
    check("t3_nvalid", valid_t.size() - nv, 0);
    check("t3_data_out", data_out, 8'hFF);

    // 4: 3-cycle low glitch
    nv = valid_t.size(); nf = ferr_t.size(); t0 = cyc;
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    repeat (30) step();
    check("t4_busy_rise", busy_rise, t0 + 3);
    check("t4_busy_len", busy_fall - busy_rise, 5);
    check("t4_nvalid", valid_t.size() - nv, 0);
    check("t4_nferr", ferr_t.size() - nf, 0);
    check("t4_busy_end", busy, 1'b0);

    // 5: reset during bit 4 of 0x5A, then clean 0x81
    b = 8'h5A;
    rx = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) step();
    end
    rx = b[4];
    repeat (5) step();
    check("t5_busy_mid", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_data_out", data_out, 8'h00);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_valid", data_valid, 1'b0);
    check("t5_rst_ferr", frame_error, 1'b0);
    rx = 1'b1;
    repeat (5) step();
    rst_n = 1'b1;
    repeat (20) step();
    nv = valid_t.size(); nf = ferr_t.size();
    send_byte(8'h81, 1'b1);
    repeat (20) step();
    check("t5_nvalid", valid_t.size() - nv, 1);
    check("t5_data", vd_at(nv), 8'h81);
    check("t5_nferr", ferr_t.size() - nf, 0);
    check("t5_data_out", data_out, 8'h81);

    // 6: break, line low for 300 cycles
    nv = valid_t.size(); nf = ferr_t.size(); t0 = cyc;
    rx = 1'b0;
    repeat (300) step();
    check("t6_nvalid_break", valid_t.size() - nv, 0);
    rx = 1'b1;
    repeat (150) step();
    check("t6_nferr", ferr_t.size() - nf, 3);
    check("t6_ftime0", ft_at(nf), t0 + 98);
    check("t6_gap1", ft_at(nf + 1) - ft_at(nf), 96);
    check("t6_gap2", ft_at(nf + 2) - ft_at(nf + 1), 96);
    check("t6_busy_end", busy, 1'b0);

    check("strobe_exclusive", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
